wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Drives the register file's single write port (write enable, destination, write data) by merging two result sources.
- Source 1: the in-order pipeline writeback, which has fixed priority and is never back-pressured.
- Source 2: long-latency unit results (load/MDU) with a valid/ready handshake. They are buffered in a small FIFO and drained into idle write slots.
- Also keeps a per-register pending scoreboard for the hazard logic.

Parameters:
- XLEN, 32, data width of results and write port.
- FIFO_DEPTH, 4, long-latency result buffer entries; power of two, >= 2.
- STARVE_LIMIT, 8, consecutive denied cycles before forced drain; used only with WB_STARVE_GUARD_EN.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- pipe_we_i  input  1  pipeline writeback valid this cycle.
- pipe_rd_i  input  5  pipeline destination register.
- pipe_data_i  input  XLEN  pipeline result.
- lu_valid_i  input  1  long-latency result valid.
- lu_ready_o  output  1  FIFO can accept a result.
- lu_rd_i  input  5  long-latency destination register.
- lu_data_i  input  XLEN  long-latency result.
- issue_i  input  1  long-latency op issued.
- issue_rd_i  input  5  destination of the issued op.
- pending_o  output  32  bit n = 1 while xn awaits a long-latency result.
- reg_write_o  output  1  register file write enable.
- rd_o  output  5  register file write destination.
- rd_din_o  output  XLEN  register file write data.
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- pipe_stall_o  output  1  pipeline must hold its writeback (guard feature only).

Behaviour:
- Reset (rst_i=1 at clock edge) sets: FIFO empty, fifo_count_o=0, pending_o=0, reg_write_o=0, rd_o=0, rd_din_o=0, pipe_stall_o=0, starve counter=0.
- Reset mid-operation discards all buffered results and pending bits. lu_ready_o=1 on the first cycle after reset.
- lu_ready_o = (count != FIFO_DEPTH), combinational from registered state.
- Handshake: a push occurs when lu_valid_i && lu_ready_o. lu_valid_i must hold with stable data until accepted.
- Full FIFO: a push is refused even if a pop occurs in the same cycle.
- An accepted result with lu_rd_i==0 is consumed but not stored: no write, count unchanged.
- Write port outputs are registered.
  - Pipeline result appears on reg_write_o/rd_o/rd_din_o one cycle after pipe_we_i.
  - A long-latency result appears no earlier than two cycles after acceptance.
- Slot selection, per cycle:
  - If pipe_we_i && pipe_rd_i!=0: register the pipeline write.
  - Else if FIFO non-empty: pop the head and register its write.
  - Else reg_write_o=0 next cycle.
  - pipe_we_i with pipe_rd_i==0 is dropped and leaves the slot free for a FIFO pop.
- Simultaneous push and pop on a non-full FIFO: count unchanged, order preserved.
- Pointers wrap modulo FIFO_DEPTH. Results leave strictly in acceptance order.
- Scoreboard:
  - issue_i && issue_rd_i!=0 sets pending bit issue_rd_i.
  - A FIFO pop clears the bit of the popped rd, on the same edge that registers the write.
  - Same register set and cleared in one cycle: set wins.
  - pending_o[0] is constant 0.
  - Consumed x0 results clear nothing.
- rd_o/rd_din_o hold their last values while reg_write_o=0.

Optional Feature:
- Macro WB_STARVE_GUARD_EN.
- Defined:
  - A starve counter increments each cycle the FIFO is non-empty and a pipeline write takes the slot.
  - It resets to 0 on any pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, pipe_stall_o is registered high for exactly one cycle.
  - In that cycle the FIFO head is granted and pipe_we_i is ignored; the pipeline holds and re-presents that writeback next cycle.
  - The counter then resets.
- Undefined: pipe_stall_o tied 0, no counter, pure pipeline priority.

Test Plan:
- Reset, then pipe_we_i=1, pipe_rd_i=5, pipe_data_i=0xDEADBEEF for 1 cycle -> next cycle reg_write_o=1, rd_o=5, rd_din_o=0xDEADBEEF; the cycle after, reg_write_o=0.
- issue_rd_i=7, then lu result rd=7 data=0x1234 with pipeline idle -> pending_o[7]=1 until the write; reg_write_o=1, rd_o=7, rd_din_o=0x1234 two cycles after acceptance; pending_o[7]=0 on the same edge.
- Pipeline writes every cycle while 5 lu results (rd 1..5) are offered, FIFO_DEPTH=4 -> 4 accepted, lu_ready_o=0, fifo_count_o=4, no lu writes. Pipeline stops -> rd 1,2,3,4 written in order, then rd 5 accepted and written.
- Pipe write to x0 and lu result to x0 -> no reg_write_o; fifo_count_o stays 0; pending_o stays 0.
- FIFO holding 2 entries, rst_i=1 for 1 cycle -> fifo_count_o=0, pending_o=0, reg_write_o=0; no buffered result is ever written afterwards.
- WB_STARVE_GUARD_EN, STARVE_LIMIT=8, FIFO non-empty, continuous pipe writes -> after 8 denied cycles pipe_stall_o=1 for one cycle and the FIFO head is written; the held pipe write is written the following cycle.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Register-file write-port arbiter. Merges the in-order pipeline
//             writeback (fixed priority, never back-pressured) with buffered
//             long-latency (load/MDU) results that drain into idle write
//             slots. Also keeps a per-register pending scoreboard.
//  Ports    : clk_i/rst_i        clock, synchronous active-high reset
//             pipe_*_i           pipeline writeback (we, rd, data)
//             lu_*               long-latency result valid/ready handshake
//             issue_i/issue_rd_i long-latency issue, sets pending bit
//             pending_o          per-register "awaiting result" bits
//             reg_write_o/rd_o/rd_din_o  registered write port
//             fifo_count_o       buffer occupancy
//             pipe_stall_o       pipeline hold request (starve guard only)
//  Options  : define WB_STARVE_GUARD_EN to enable the starvation guard, which
//             forces one FIFO drain after STARVE_LIMIT denied cycles.
//  Revision : 1.0  initial release
// ============================================================================
module wb_arbiter #(
   parameter int XLEN         = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          pipe_we_i,
   input  logic [4:0]                    pipe_rd_i,
   input  logic [XLEN-1:0]               pipe_data_i,
   input  logic                          lu_valid_i,
   output logic                          lu_ready_o,
   input  logic [4:0]                    lu_rd_i,
   input  logic [XLEN-1:0]               lu_data_i,
   input  logic                          issue_i,
   input  logic [4:0]                    issue_rd_i,
   output logic [31:0]                   pending_o,
   output logic                          reg_write_o,
   output logic [4:0]                    rd_o,
   output logic [XLEN-1:0]               rd_din_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          pipe_stall_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   // Parameter sanity checks at elaboration.
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("wb_arbiter: FIFO_DEPTH must be a power of two >= 2");
   end
   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("wb_arbiter: STARVE_LIMIT must be >= 1");
   end

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [4:0]       rd_mem_q   [FIFO_DEPTH];
   logic [XLEN-1:0]  data_mem_q [FIFO_DEPTH];
   logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic [31:0]      pending_q, pending_d;
   logic             reg_write_q;
   logic [4:0]       rd_q;
   logic [XLEN-1:0]  din_q;

   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_pipe_take;
   logic             w_force;
   logic [4:0]       w_head_rd;
   logic [XLEN-1:0]  w_head_data;

   assign w_empty     = (count_q == '0);
   assign lu_ready_o  = (count_q != CW'(FIFO_DEPTH));
   assign w_head_rd   = rd_mem_q[rd_ptr_q];
   assign w_head_data = data_mem_q[rd_ptr_q];

   // x0 results complete the handshake but are never stored.
   assign w_push      = lu_valid_i && lu_ready_o && (lu_rd_i != 5'd0);
   // x0 pipeline writes leave the slot free for a drain.
   assign w_pipe_take = pipe_we_i && (pipe_rd_i != 5'd0) && !w_force;
   assign w_pop       = !w_pipe_take && !w_empty;

   // ------------------------------------------------------------------------
   // Optional starvation guard
   // ------------------------------------------------------------------------
`ifdef WB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_q, starve_d;
   logic          stall_q, stall_d;

   always_comb begin
      starve_d = starve_q;
      if (w_pop || w_empty) begin
         starve_d = '0;
      end else if (w_pipe_take) begin
         starve_d = starve_q + SW'(1);
      end
      // A stall cycle always pops, so the counter is back to 0 afterwards
      // and the pulse cannot repeat back to back.
      stall_d = !stall_q && (starve_d == SW'(STARVE_LIMIT));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_q <= '0;
         stall_q  <= 1'b0;
      end else begin
         starve_q <= starve_d;
         stall_q  <= stall_d;
      end
   end

   // While stalled the FIFO head owns the slot; the pipeline re-presents
   // its writeback on the following cycle.
   assign w_force      = stall_q;
   assign pipe_stall_o = stall_q;
`else
   assign w_force      = 1'b0;
   assign pipe_stall_o = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      count_d = count_q;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Clear before set so an issue in the same cycle as the drain wins.
   always_comb begin
      pending_d = pending_q;
      if (w_pop) begin
         pending_d[w_head_rd] = 1'b0;
      end
      if (issue_i && (issue_rd_i != 5'd0)) begin
         pending_d[issue_rd_i] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         pending_q   <= '0;
         reg_write_q <= 1'b0;
         rd_q        <= '0;
         din_q       <= '0;
      end else begin
         count_q   <= count_d;
         pending_q <= pending_d;
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         if (w_pipe_take) begin
            reg_write_q <= 1'b1;
            rd_q        <= pipe_rd_i;
            din_q       <= pipe_data_i;
         end else if (w_pop) begin
            reg_write_q <= 1'b1;
            rd_q        <= w_head_rd;
            din_q       <= w_head_data;
         end else begin
            // Destination and data hold their last values when idle.
            reg_write_q <= 1'b0;
         end
      end
   end

   // Buffer storage carries no reset; occupancy and pointers qualify it.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         rd_mem_q[wr_ptr_q]   <= lu_rd_i;
         data_mem_q[wr_ptr_q] <= lu_data_i;
      end
   end

   assign pending_o    = pending_q;
   assign reg_write_o  = reg_write_q;
   assign rd_o         = rd_q;
   assign rd_din_o     = din_q;
   assign fifo_count_o = count_q;

endmodule
`default_nettype wire
